pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives write-enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use stalls, taken-branch flushes (branch resolved in MEM via PCSrc), data-memory wait freezes and debug halt/drain.
- Keeps saturating performance counters. Operand forwarding is handled by the existing forwarding unit; this block only stalls, flushes and freezes.

Parameters:
CNT_W, 32, width of each performance counter
MEM_TIMEOUT, 16, max consecutive dmem wait cycles before forced release
DRAIN_CYCLES, 4, bubble cycles needed to empty ID..WB before HALTED

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
MemRead_EX  input  1  instruction in EX is a load
rd_EX  input  5  destination reg of instruction in EX
rs1_ID  input  5  rs1 field of instruction in ID
rs2_ID  input  5  rs2 field of instruction in ID
use_rs1_ID  input  1  ID instruction reads rs1
use_rs2_ID  input  1  ID instruction reads rs2
PCSrc  input  1  taken branch resolved in MEM this cycle
dmem_req  input  1  MEM-stage instruction accesses data memory
dmem_ready  input  1  data memory completes access this cycle
halt_req  input  1  level request to halt fetch and drain
pc_write  output  1  PC register update enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  load bubble into IF/ID
idex_write  output  1  ID/EX load enable
idex_flush  output  1  load bubble into ID/EX
exmem_write  output  1  EX/MEM load enable
exmem_flush  output  1  load bubble into EX/MEM
memwb_write  output  1  MEM/WB load enable
halted  output  1  pipeline empty and halted
mem_timeout  output  1  sticky: a dmem wait hit MEM_TIMEOUT
stall_cycles  output  CNT_W  load-use stall cycles
wait_cycles  output  CNT_W  dmem freeze cycles
flush_count  output  CNT_W  taken-branch flush events

Behaviour:
- Reset (synchronous): state=RUN, wait timer=0, drain counter=0, mem_timeout=0, all counters=0. While reset is high, every *_write=1 and every *_flush=0.
- Strobes are combinational from state and inputs, so they act in the same cycle. State, counters and timer are registered.
- Flush outranks write: a stage loads a bubble whenever its *_flush=1, regardless of its *_write.
- Default strobes: all *_write=1, all *_flush=0.
- load_use = MemRead_EX && rd_EX!=0 && ((use_rs1_ID && rs1_ID==rd_EX) || (use_rs2_ID && rs2_ID==rd_EX)).
- mem_wait = dmem_req && !dmem_ready.
- RUN priority:
  1. mem_wait: freeze, i.e. all *_write=0 and all flushes 0. Next state MEM_WAIT, timer=1, wait_cycles+1.
  2. PCSrc: ifid_flush=idex_flush=exmem_flush=1, writes 1, flush_count+1.
  3. halt_req: next state DRAIN, drain counter=0. Outputs this cycle are evaluated as DRAIN outputs.
  4. load_use: pc_write=0, ifid_write=0, idex_flush=1, stall_cycles+1.
  5. Otherwise default strobes.
- MEM_WAIT:
  - If mem_wait && timer<MEM_TIMEOUT: freeze, timer+1, wait_cycles+1.
  - If dmem_ready, or timer==MEM_TIMEOUT: outputs are evaluated with RUN priorities 2-5 in the same cycle, next state per those rules (RUN or DRAIN), timer=0.
  - Timeout case additionally sets mem_timeout; it stays set until reset.
- DRAIN:
  - pc_write=0, ifid_flush=1. The PC holds, and the instruction at PC is refetched on resume.
  - mem_wait: freeze, counter holds, wait_cycles+1.
  - PCSrc: flushes as in RUN, counter+1.
  - load_use: ifid_write=0, idex_flush=1, counter holds, stall_cycles+1.
  - Otherwise counter+1. When counter reaches DRAIN_CYCLES-1 with no hold, next state is HALTED.
  - halt_req deassert mid-drain is ignored; drain completes.
- HALTED:
  - halted=1, pc_write=0, ifid_flush=1, other writes 1.
  - halt_req low: next state RUN; halted drops the following cycle.
- PCSrc and mem_wait together: mem_wait wins; PCSrc is re-evaluated on release.
- Counters saturate at all-ones.

Test Plan:
- lw x5 in EX, add in ID with rs1=x5 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. Same case with rd_EX=0 -> no stall.
- PCSrc=1 for one cycle in RUN -> ifid/idex/exmem flush=1 that cycle only; flush_count=1; pc_write=1.
- dmem_req=1 with dmem_ready low for 3 cycles -> 3 freeze cycles (all writes 0); release on the ready cycle; wait_cycles=3, mem_timeout=0.
- dmem_ready held low with MEM_TIMEOUT=16 -> released after 16 freeze cycles; mem_timeout=1, stays 1 until reset.
- halt_req=1 with no hazards -> pc_write=0 from the same cycle; halted=1 after 4 cycles. Deassert halt_req -> RUN next cycle, fetch resumes at the held PC.
- Reset asserted mid-MEM_WAIT and mid-DRAIN -> next cycle RUN, counters 0, halted=0, mem_timeout=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/freeze sequencing and perf counters for the 5-stage pipeline
module pipeline_hazard_controller #(
    parameter int CNT_W        = 32,
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             PCSrc,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_write,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] wait_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX  = TW'(MEM_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          set_timeout;
    logic          inc_stall, inc_wait, inc_flush;
    logic          load_use, mem_wait, run_rules, freeze;

    assign load_use = MemRead_EX && (rd_EX != 5'd0) &&
                      ((use_rs1_ID && (rs1_ID == rd_EX)) || (use_rs2_ID && (rs2_ID == rd_EX)));
    assign mem_wait = dmem_req && !dmem_ready;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        exmem_flush   = 1'b0;
        memwb_write   = 1'b1;
        halted        = 1'b0;
        state_nxt     = state;
        timer_nxt     = timer;
        drain_cnt_nxt = drain_cnt;
        set_timeout   = 1'b0;
        inc_stall     = 1'b0;
        inc_wait      = 1'b0;
        inc_flush     = 1'b0;
        run_rules     = 1'b0;
        freeze        = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    freeze    = 1'b1;
                    inc_wait  = 1'b1;
                    timer_nxt = TW'(1);
                    state_nxt = ST_MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_wait && (timer < TIMER_MAX)) begin
                    freeze    = 1'b1;
                    inc_wait  = 1'b1;
                    timer_nxt = timer + 1'b1;
                end else begin
                    // Release: either the access completed or the wait was forced out.
                    run_rules   = 1'b1;
                    timer_nxt   = '0;
                    set_timeout = mem_wait;
                end
            end
            ST_DRAIN: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                if (mem_wait) begin
                    freeze   = 1'b1;
                    inc_wait = 1'b1;
                end else if (load_use && !PCSrc) begin
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    inc_stall  = 1'b1;
                end else begin
                    if (PCSrc) begin
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        inc_flush   = 1'b1;
                    end
                    drain_cnt_nxt = drain_cnt + 1'b1;
                    if (drain_cnt_nxt == DRAIN_LAST) begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                halted     = 1'b1;
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                if (!halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        // Branch, halt entry and load-use, shared by RUN and the MEM_WAIT release cycle.
        if (run_rules) begin
            state_nxt = ST_RUN;
            if (PCSrc) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                inc_flush   = 1'b1;
            end else begin
                if (halt_req) begin
                    pc_write      = 1'b0;
                    ifid_flush    = 1'b1;
                    drain_cnt_nxt = '0;
                    state_nxt     = ST_DRAIN;
                end
                if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    inc_stall  = 1'b1;
                end
            end
        end

        if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_write  = 1'b0;
            idex_flush  = 1'b0;
            exmem_write = 1'b0;
            exmem_flush = 1'b0;
            memwb_write = 1'b0;
        end

        if (reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_write  = 1'b1;
            idex_flush  = 1'b0;
            exmem_write = 1'b1;
            exmem_flush = 1'b0;
            memwb_write = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            timer        <= '0;
            drain_cnt    <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            wait_cycles  <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (inc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (inc_wait && (wait_cycles != '1)) begin
                wait_cycles <= wait_cycles + 1'b1;
            end
            if (inc_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed table, corner sequences and random run against a reference model
module tb_pipeline_hazard_controller;

    localparam int     CW     = 8;
    localparam longint CMAX   = 255;
    localparam int     MTO    = 16;
    localparam int     DRAINC = 4;
    localparam int     M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

    // Strobe vector order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w
    localparam logic [7:0] S_DEF   = 8'b1101_0101;
    localparam logic [7:0] S_STALL = 8'b0001_1101;
    localparam logic [7:0] S_BR    = 8'b1111_1111;
    localparam logic [7:0] S_FRZ   = 8'b0000_0000;
    localparam logic [7:0] S_DRAIN = 8'b0111_0101;

    logic clk, reset;
    logic MemRead_EX, use_rs1_ID, use_rs2_ID, PCSrc, dmem_req, dmem_ready, halt_req;
    logic [4:0] rd_EX, rs1_ID, rs2_ID;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, exmem_flush, memwb_write, halted, mem_timeout;
    logic [CW-1:0] stall_cycles, wait_cycles, flush_count;

    int checks = 0;
    int failures = 0;

    int     m_mode, m_timer, m_drain, n_mode, n_timer, n_drain;
    bit     m_to, n_to;
    longint m_sc, m_wc, m_fc, n_sc, n_wc, n_fc;
    logic [7:0] e_s;
    bit         e_h;

    typedef struct {
        bit rst; bit mre; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        bit u1; bit u2; bit pcs; bit dreq; bit drdy; bit halt;
        logic [7:0] exp_s; bit exp_h;
    } vec_t;
    vec_t tbl[$];

    pipeline_hazard_controller #(.CNT_W(CW), .MEM_TIMEOUT(MTO), .DRAIN_CYCLES(DRAINC)) dut (
        .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .PCSrc(PCSrc), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .exmem_flush(exmem_flush), .memwb_write(memwb_write), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .wait_cycles(wait_cycles),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit rst, bit mre, int rd, int rs1, int rs2, bit u1, bit u2,
                                bit pcs, bit dreq, bit drdy, bit halt, logic [7:0] es, bit eh);
        vec_t v;
        v.rst = rst; v.mre = mre; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = u1; v.u2 = u2; v.pcs = pcs; v.dreq = dreq; v.drdy = drdy; v.halt = halt;
        v.exp_s = es; v.exp_h = eh;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst; MemRead_EX = v.mre; rd_EX = v.rd; rs1_ID = v.rs1; rs2_ID = v.rs2;
        use_rs1_ID = v.u1; use_rs2_ID = v.u2; PCSrc = v.pcs; dmem_req = v.dreq;
        dmem_ready = v.drdy; halt_req = v.halt;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF, 0));
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic longint sat(longint x, bit inc);
        return (inc && x < CMAX) ? x + 1 : x;
    endfunction

    // Decides per cycle which pipeline action applies (freeze / branch flush / stall / fetch hold)
    // and derives the strobes from those decisions.
    task automatic model_eval();
        bit mw, lu, frz, br, stl, hold, bub;
        mw = dmem_req && !dmem_ready;
        lu = MemRead_EX && rd_EX != 0 &&
             ((use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX));
        frz = 0; br = 0; stl = 0; hold = 0; bub = 0; e_h = 0;
        n_mode = m_mode; n_timer = m_timer; n_drain = m_drain; n_to = m_to;
        if (reset) begin
            n_mode = M_RUN; n_timer = 0; n_drain = 0; n_to = 0;
        end else if (m_mode == M_HALT) begin
            e_h = 1; hold = 1; bub = 1;
            if (!halt_req) n_mode = M_RUN;
        end else if (m_mode == M_DRAIN) begin
            hold = 1; bub = 1;
            if (mw) frz = 1;
            else begin
                if (PCSrc) br = 1;
                else if (lu) stl = 1;
                if (!stl) begin
                    n_drain = m_drain + 1;
                    if (n_drain == DRAINC - 1) n_mode = M_HALT;
                end
            end
        end else begin
            if (mw && (m_mode == M_RUN || m_timer < MTO)) begin
                frz = 1; n_mode = M_WAIT; n_timer = m_timer + 1;
            end else begin
                if (m_mode == M_WAIT && mw) n_to = 1;
                n_timer = 0; n_mode = M_RUN;
                if (PCSrc) br = 1;
                else begin
                    stl = lu;
                    if (halt_req) begin hold = 1; bub = 1; n_mode = M_DRAIN; n_drain = 0; end
                end
            end
        end
        e_s = {!frz && !hold && !stl, !frz && !stl, !frz && (br || bub), !frz,
               !frz && (br || stl), !frz, !frz && br, !frz};
        n_sc = reset ? 0 : sat(m_sc, stl);
        n_wc = reset ? 0 : sat(m_wc, frz);
        n_fc = reset ? 0 : sat(m_fc, br);
    endtask

    task automatic step(input bit use_exp, input logic [7:0] exp_s, input bit exp_h);
        logic [7:0] act_s;
        #1;
        act_s = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_write, exmem_flush, memwb_write};
        model_eval();
        check("strobes_model", act_s, e_s);
        check("halted_model", halted, e_h);
        check("mem_timeout_model", mem_timeout, m_to);
        check("stall_cycles_model", stall_cycles, m_sc);
        check("wait_cycles_model", wait_cycles, m_wc);
        check("flush_count_model", flush_count, m_fc);
        if (use_exp) begin
            check("strobes_table", act_s, exp_s);
            check("halted_table", halted, exp_h);
        end
        @(posedge clk);
        m_mode = n_mode; m_timer = n_timer; m_drain = n_drain; m_to = n_to;
        m_sc = n_sc; m_wc = n_wc; m_fc = n_fc;
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = M_RUN; m_timer = 0; m_drain = 0; m_to = 0; m_sc = 0; m_wc = 0; m_fc = 0;

        //              rst mre rd rs1 rs2 u1 u2 pcs dreq drdy halt exp      halted
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, 0, S_STALL, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 1, 7, 3, 7, 1, 1, 0, 0, 0, 0, S_STALL, 0));
        tbl.push_back(mk(0, 1, 7, 3, 7, 1, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, S_BR,    0));
        tbl.push_back(mk(0, 1, 5, 5, 0, 1, 0, 1, 0, 0, 0, S_BR,    0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_FRZ,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, S_DEF,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, S_FRZ,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, S_BR,    0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DRAIN, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DRAIN, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DRAIN, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_DEF,   0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            step(1, tbl[i].exp_s, tbl[i].exp_h);
        end
        check("table_stall_cycles", stall_cycles, 2);
        check("table_wait_cycles", wait_cycles, 4);
        check("table_flush_count", flush_count, 3);
        check("table_mem_timeout", mem_timeout, 0);

        // dmem never ready: 16 freeze cycles, forced release, sticky timeout flag
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < MTO; i++) step(1, S_FRZ, 0);
        step(1, S_DEF, 0);
        idle();
        check("timeout_set", mem_timeout, 1);
        check("timeout_wait_cycles", wait_cycles, 20);
        for (int i = 0; i < 3; i++) step(1, S_DEF, 0);
        check("timeout_sticky", mem_timeout, 1);

        // reset in the middle of a memory wait
        dmem_req = 1'b1;
        step(1, S_FRZ, 0);
        step(1, S_FRZ, 0);
        idle(); reset = 1'b1;
        step(1, S_DEF, 0);
        idle();
        check("rst_wait_mem_timeout", mem_timeout, 0);
        check("rst_wait_wait_cycles", wait_cycles, 0);
        check("rst_wait_flush_count", flush_count, 0);
        step(1, S_DEF, 0);

        // reset in the middle of a drain
        halt_req = 1'b1;
        step(1, S_DRAIN, 0);
        step(1, S_DRAIN, 0);
        idle(); reset = 1'b1;
        step(1, S_DEF, 0);
        idle();
        step(1, S_DEF, 0);
        check("rst_drain_halted", halted, 0);
        check("rst_drain_stall_cycles", stall_cycles, 0);

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            MemRead_EX = 1'($urandom_range(0, 1));
            rd_EX      = 5'($urandom_range(0, 3));
            rs1_ID     = 5'($urandom_range(0, 3));
            rs2_ID     = 5'($urandom_range(0, 3));
            use_rs1_ID = 1'($urandom_range(0, 1));
            use_rs2_ID = 1'($urandom_range(0, 1));
            PCSrc      = ($urandom_range(0, 5) == 0);
            dmem_req   = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            if ((i % 500) < 40) begin
                dmem_req = 1'b1; dmem_ready = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) halt_req = !halt_req;
            step(0, 8'h00, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
